// File: rtl/kvaz_multi.sv
// Multi-disk RAM-disk mapper: per-disk control registers and window/stack claims,
// stack-over-ram and lowest-index priority, registered SRAM page select.
module kvaz_multi_disk #(
  parameter int EXT_WINDOWS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clke,
  input  logic       sel_i,
  input  logic [7:0] data_i,
  input  logic [3:0] nib_i,
  input  logic       stack_i,
  input  logic       acc_i,
  output logic [7:0] ctl_o,
  output logic       stk_claim_o,
  output logic       ram_claim_o,
  output logic [1:0] pg_o
);
  localparam bit EXT = (EXT_WINDOWS != 0);

  logic [7:0] ctl_q, ctl_d;
  logic       win;

  always_comb begin
    ctl_d = ctl_q;
    if (clke && sel_i) ctl_d = data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) ctl_q <= '0;
    else       ctl_q <= ctl_d;
  end

  always_comb begin
    win = (nib_i >= 4'hA) && (nib_i <= 4'hD);
    if (EXT && ctl_q[6] && (nib_i[3:1] == 3'b100)) win = 1'b1;
    if (EXT && ctl_q[7] && (nib_i[3:1] == 3'b111)) win = 1'b1;
  end

  // A stack access never falls through to a window claim.
  assign stk_claim_o = ctl_q[4] & stack_i & acc_i;
  assign ram_claim_o = ctl_q[5] & win & acc_i & ~stack_i;
  assign pg_o        = stack_i ? ctl_q[3:2] : ctl_q[1:0];
  assign ctl_o       = ctl_q;
endmodule

module kvaz_multi #(
  parameter int NDISKS      = 4,
  parameter int PAGE_W      = 5,
  parameter int EXT_WINDOWS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clke,
  input  logic [15:0]       address,
  input  logic [NDISKS-1:0] select,
  input  logic [7:0]        data_in,
  input  logic              stack,
  input  logic              memwr,
  input  logic              memrd,
  input  logic              conflict_clr,
  output logic [PAGE_W-1:0] bigram_addr,
  output logic              hit,
  output logic              conflict,
  output logic [7:0]        debug
);
  logic                   acc;
  logic [NDISKS-1:0]      stk_claim, ram_claim, win_claim;
  logic [NDISKS-1:0][7:0] ctl;
  logic [NDISKS-1:0][1:0] pg;
  logic [PAGE_W-1:0]      win_page;
  logic [7:0]             win_ctl;
  int                     n_claim;
  logic                   any_claim;
  logic                   unused_addr;

  logic [PAGE_W-1:0] bigram_q, bigram_d;
  logic              hit_q, hit_d, conf_q, conf_d;
  logic [7:0]        debug_q, debug_d;

  assign acc         = memrd | memwr;
  assign unused_addr = ^address[11:0];

  for (genvar d = 0; d < NDISKS; d++) begin : g_disk
    kvaz_multi_disk #(.EXT_WINDOWS(EXT_WINDOWS)) u_disk (
      .clk         (clk),
      .reset       (reset),
      .clke        (clke),
      .sel_i       (select[d]),
      .data_i      (data_in),
      .nib_i       (address[15:12]),
      .stack_i     (stack),
      .acc_i       (acc),
      .ctl_o       (ctl[d]),
      .stk_claim_o (stk_claim[d]),
      .ram_claim_o (ram_claim[d]),
      .pg_o        (pg[d])
    );
  end

  // Stack class wins outright; downward scan leaves the lowest claimant.
  always_comb begin
    win_claim = (|stk_claim) ? stk_claim : ram_claim;
    any_claim = |win_claim;
    win_page  = '0;
    win_ctl   = '0;
    n_claim   = 0;
    for (int d = NDISKS - 1; d >= 0; d--) begin
      if (win_claim[d]) begin
        win_page = PAGE_W'(1 + 4 * d) + PAGE_W'(pg[d]);
        win_ctl  = ctl[d];
      end
    end
    for (int d = 0; d < NDISKS; d++) n_claim = n_claim + (win_claim[d] ? 1 : 0);
  end

  always_comb begin
    bigram_d = bigram_q;
    hit_d    = hit_q;
    conf_d   = conf_q;
    debug_d  = debug_q;
    if (clke) begin
      bigram_d = win_page;
      hit_d    = any_claim;
      if (any_claim)        debug_d = win_ctl;
      if (n_claim > 1)      conf_d  = 1'b1;
      else if (conflict_clr) conf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bigram_q <= '0;
      hit_q    <= 1'b0;
      conf_q   <= 1'b0;
      debug_q  <= '0;
    end else begin
      bigram_q <= bigram_d;
      hit_q    <= hit_d;
      conf_q   <= conf_d;
      debug_q  <= debug_d;
    end
  end

  assign bigram_addr = bigram_q;
  assign hit         = hit_q;
  assign conflict    = conf_q;
  assign debug       = debug_q;
endmodule
